// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer bank.
// Covers register offsets, CTRL bit layout and the per-channel write-enable bundle.
package timer_pkg;

  localparam int unsigned PRESC_WID      = 8;
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_AUTO      = 1;
  localparam int unsigned CTRL_IE        = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_RELOAD = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  typedef struct packed {
    logic ctrl;
    logic reload;
    logic count;
    logic status;
  } ch_we_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/reload/count registers, prescaler,
// overflow handling and the sticky pending flag with its registered irq.
module timer_channel #(
  parameter int unsigned TIMER_WID = 16,
  parameter int unsigned PRESC_WID = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  timer_pkg::ch_we_t    we,
  input  logic [TIMER_WID-1:0] datain,
  output logic [TIMER_WID-1:0] ctrl_val,
  output logic [TIMER_WID-1:0] reload_val,
  output logic [TIMER_WID-1:0] count_val,
  output logic [TIMER_WID-1:0] status_val,
  output logic                 irq_c,
  output logic                 irq
);
  import timer_pkg::*;

  logic                 en_q, en_d;
  logic                 auto_q, auto_d;
  logic                 ie_q, ie_d;
  logic [PRESC_WID-1:0] presc_q, presc_d;
  logic [PRESC_WID-1:0] pcnt_q, pcnt_d;
  logic [TIMER_WID-1:0] reload_q, reload_d;
  logic [TIMER_WID-1:0] count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 irq_q, irq_d;
  logic                 tick;
  logic                 ovf;
  logic                 unused_datain;

  assign unused_datain = ^datain;

  // Bus writes are applied last so they win over tick/overflow updates.
  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    ie_d      = ie_q;
    presc_d   = presc_q;
    pcnt_d    = '0;
    reload_d  = reload_q;
    count_d   = count_q;
    pending_d = pending_q;
    irq_d     = pending_q & ie_q;

    tick = en_q && (pcnt_q == presc_q);
    ovf  = tick && (count_q == '1);

    if (en_q && !tick) begin
      pcnt_d = pcnt_q + PRESC_WID'(1);
    end

    if (ovf) begin
      count_d   = reload_q;
      pending_d = 1'b1;
      if (!auto_q) begin
        en_d = 1'b0;
      end
    end else if (tick) begin
      count_d = count_q + TIMER_WID'(1);
    end

    if (we.ctrl) begin
      en_d    = datain[CTRL_EN];
      auto_d  = datain[CTRL_AUTO];
      ie_d    = datain[CTRL_IE];
      presc_d = datain[CTRL_PRESC_LSB +: PRESC_WID];
      if (!datain[CTRL_EN]) begin
        pcnt_d = '0;
      end
    end
    if (we.reload) begin
      reload_d = datain;
    end
    if (we.count) begin
      count_d = datain;
    end
    if (we.status && datain[0] && !ovf) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    ctrl_val                                = '0;
    ctrl_val[CTRL_EN]                       = en_q;
    ctrl_val[CTRL_AUTO]                     = auto_q;
    ctrl_val[CTRL_IE]                       = ie_q;
    ctrl_val[CTRL_PRESC_LSB +: PRESC_WID]   = presc_q;
    reload_val                              = reload_q;
    count_val                               = count_q;
    status_val                              = TIMER_WID'(pending_q);
    irq_c                                   = pending_q & ie_q;
  end

  assign irq = irq_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent timer channels on the peripheral bus:
// address decode, registered read mux and the combined interrupt line.
module timer_bank #(
  parameter int unsigned TIMER_WID = 16,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PRESC_WID = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [$clog2(NUM_CH)+1:0]   addr,
  input  logic [TIMER_WID-1:0]        datain,
  output logic [TIMER_WID-1:0]        dataout,
  output logic [NUM_CH-1:0]           irq_vec,
  output logic                        intrup
);
  import timer_pkg::*;

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]      ch_idx;
  reg_e                 reg_sel;
  ch_we_t               we_ch      [NUM_CH];
  logic [TIMER_WID-1:0] ctrl_val   [NUM_CH];
  logic [TIMER_WID-1:0] reload_val [NUM_CH];
  logic [TIMER_WID-1:0] count_val  [NUM_CH];
  logic [TIMER_WID-1:0] status_val [NUM_CH];
  logic [NUM_CH-1:0]    irq_c_vec;
  logic [TIMER_WID-1:0] rd_val;
  logic [TIMER_WID-1:0] dataout_q, dataout_d;
  logic                 intrup_q, intrup_d;

  always_comb begin
    ch_idx  = CH_W'(addr >> 2);
    reg_sel = reg_e'(addr[1:0]);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit      = cs && wr && (ch_idx == CH_W'(i));
    assign we_ch[i] = {hit && (reg_sel == REG_CTRL),
                       hit && (reg_sel == REG_RELOAD),
                       hit && (reg_sel == REG_COUNT),
                       hit && (reg_sel == REG_STATUS)};

    timer_channel #(
      .TIMER_WID (TIMER_WID),
      .PRESC_WID (PRESC_WID)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .we         (we_ch[i]),
      .datain     (datain),
      .ctrl_val   (ctrl_val[i]),
      .reload_val (reload_val[i]),
      .count_val  (count_val[i]),
      .status_val (status_val[i]),
      .irq_c      (irq_c_vec[i]),
      .irq        (irq_vec[i])
    );
  end

  // Read mux sees pre-edge register values, so a same-cycle write reads old data.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL:   rd_val = ctrl_val[ch_idx];
      REG_RELOAD: rd_val = reload_val[ch_idx];
      REG_COUNT:  rd_val = count_val[ch_idx];
      REG_STATUS: rd_val = status_val[ch_idx];
    endcase
    dataout_d = dataout_q;
    if (cs && rd) begin
      dataout_d = rd_val;
    end
    intrup_d = |irq_c_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataout_q <= '0;
      intrup_q  <= 1'b0;
    end else begin
      dataout_q <= dataout_d;
      intrup_q  <= intrup_d;
    end
  end

  assign dataout = dataout_q;
  assign intrup  = intrup_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: reads are scoreboarded, interrupt lines checked in place.
module tb_timer_bank;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 4;
  localparam int R_CTRL   = 0;
  localparam int R_RELOAD = 1;
  localparam int R_COUNT  = 2;
  localparam int R_STATUS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [W-1:0]  datain;
  logic [W-1:0]  dataout;
  logic [N-1:0]  irq_vec;
  logic          intrup;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [W-1:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  timer_bank #(.TIMER_WID(W), .NUM_CH(N), .PRESC_WID(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .irq_vec (irq_vec),
    .intrup  (intrup)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", W'(1), W'(0));
    end else begin
      e = sb.pop_front();
      check(e.tag, dataout, e.exp);
    end
  endtask

  task automatic bus_wr(input int ch, input int r, input logic [W-1:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0;
    addr = AW'(ch * 4 + r);
    datain = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input int ch, input int r, input string tag, input logic [W-1:0] exp);
    sb.push_back('{tag, exp});
    cs = 1'b1; rd = 1'b1; wr = 1'b0;
    addr = AW'(ch * 4 + r);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    pop_check();
  endtask

  task automatic bus_wrrd(input int ch, input int r, input logic [W-1:0] d,
                          input string tag, input logic [W-1:0] exp);
    sb.push_back('{tag, exp});
    cs = 1'b1; rd = 1'b1; wr = 1'b1;
    addr = AW'(ch * 4 + r);
    datain = d;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; datain = '0;
    idle(2);
    rst = 1'b0;

    // Reset state
    check("rst_dataout", dataout, W'(0));
    check("rst_intrup", W'(intrup), W'(0));
    check("rst_irq_vec", W'(irq_vec), W'(0));
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        bus_rd(c, r, $sformatf("rst_ch%0d_r%0d", c, r), W'(0));
      end
    end
    check("rst_intrup_after_reads", W'(intrup), W'(0));

    // ch0 auto-reload, presc 0, ie
    bus_wr(0, R_RELOAD, 16'hFFF0);
    bus_wr(0, R_COUNT,  16'hFFFC);
    bus_wr(0, R_CTRL,   16'h0007);
    check("ch0_irq_start", W'(irq_vec), W'(0));
    idle(3);
    bus_rd(0, R_STATUS, "ch0_pend_before_ovf", W'(0));
    check("ch0_irq_same_cycle_as_pend", W'(irq_vec), W'(0));
    bus_rd(0, R_COUNT, "ch0_count_after_ovf", 16'hFFF0);
    check("ch0_irq_rise", W'(irq_vec), W'(4'b0001));
    check("ch0_intrup_rise", W'(intrup), W'(1));
    bus_rd(0, R_STATUS, "ch0_pend_set", W'(1));
    idle(3);
    bus_wr(0, R_STATUS, 16'h0001);
    idle(1);
    check("ch0_intrup_cleared", W'(intrup), W'(0));
    check("ch0_irq_cleared", W'(irq_vec), W'(0));
    bus_rd(0, R_STATUS, "ch0_pend_cleared", W'(0));
    bus_rd(0, R_COUNT, "ch0_count_midway", 16'hFFF8);
    idle(6);
    bus_wr(0, R_STATUS, 16'h0001);
    bus_rd(0, R_STATUS, "ch0_ovf_beats_clear", W'(1));
    bus_rd(0, R_COUNT, "ch0_second_ovf", 16'hFFF1);
    check("ch0_intrup_again", W'(intrup), W'(1));
    bus_wr(0, R_CTRL, 16'h0000);
    bus_wr(0, R_STATUS, 16'h0001);
    idle(2);
    check("ch0_quiet", W'(intrup), W'(0));

    // ch1 one-shot, presc 3
    bus_wr(1, R_RELOAD, 16'h0042);
    bus_wr(1, R_COUNT,  16'hFFFE);
    bus_wr(1, R_CTRL,   16'h0305);
    idle(7);
    bus_rd(1, R_STATUS, "ch1_pend_before_ovf", W'(0));
    bus_rd(1, R_STATUS, "ch1_pend_after_ovf", W'(1));
    bus_rd(1, R_CTRL, "ch1_ctrl_en_cleared", 16'h0304);
    bus_rd(1, R_COUNT, "ch1_count_reload", 16'h0042);
    idle(10);
    bus_rd(1, R_COUNT, "ch1_count_frozen", 16'h0042);
    check("ch1_irq_vec", W'(irq_vec), W'(4'b0010));

    // ch2 count write beats tick; wr&rd returns old value
    bus_wr(2, R_CTRL, 16'h0001);
    bus_wr(2, R_COUNT, 16'h1234);
    bus_rd(2, R_COUNT, "ch2_write_beats_tick", 16'h1234);
    bus_wrrd(2, R_COUNT, 16'h5555, "ch2_wrrd_old_value", 16'h1235);
    bus_rd(2, R_COUNT, "ch2_count_written", 16'h5555);
    bus_wr(2, R_CTRL, 16'h0000);

    // ch3 running, then synchronous reset
    bus_wr(3, R_COUNT, 16'h8000);
    bus_wr(3, R_CTRL, 16'h0F01);
    bus_rd(3, R_COUNT, "ch3_count_running", 16'h8000);
    check("pre_rst_intrup", W'(intrup), W'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_dataout", dataout, W'(0));
    check("post_rst_intrup", W'(intrup), W'(0));
    check("post_rst_irq_vec", W'(irq_vec), W'(0));
    idle(20);
    bus_rd(3, R_COUNT, "ch3_count_after_rst", W'(0));
    bus_rd(3, R_CTRL, "ch3_ctrl_after_rst", W'(0));
    bus_rd(3, R_STATUS, "ch3_status_after_rst", W'(0));
    bus_rd(1, R_STATUS, "ch1_status_after_rst", W'(0));
    bus_rd(1, R_RELOAD, "ch1_reload_after_rst", W'(0));
    check("sb_empty", W'(sb.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
